instr_encoder_loader: RTL and testbench

//  Inverse of the decode stage: accepts symbolic instructions (mnemonic + register/imm fields) over a

---
 rtl/calab_isa_pkg.sv | 116 +++++++++++
 rtl/instr_encoder_loader_if.sv | 43 ++++
 rtl/instr_encoder.sv | 61 ++++++
 rtl/instr_encoder_loader.sv | 149 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calab_isa_pkg.sv
// -----------------------------------------------------------------------------
// calab_isa_pkg
// Shared ISA definitions for the instruction encoder/loader:
//   - 32-bit word layout (field widths and bit positions)
//   - opcode values OP_NOP..OP_JMP
//   - symbolic mnemonic enum MN_NOP=0..MN_JMP=17 (values 18..31 are illegal)
//   - format classes used to select which fields go into the word
//   - mnem_info(): mnemonic -> {format, opcode}
//   - loader FSM state enum
// -----------------------------------------------------------------------------
package calab_isa_pkg;

  localparam int WORD_W = 32;
  localparam int OP_W   = 6;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  localparam int MNEM_W = 5;

  // Field LSB positions; imm overlaps rs2 and the low bits, so a word carries
  // either rs2 (R-type) or imm (all other formats), never both.
  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 21;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 11;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd3;
  localparam logic [OP_W-1:0] OP_AND  = 6'd5;
  localparam logic [OP_W-1:0] OP_OR   = 6'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 6'd7;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLA  = 6'd9;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd10;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd11;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd12;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd32;
  localparam logic [OP_W-1:0] OP_SUBI = 6'd33;
  localparam logic [OP_W-1:0] OP_LD   = 6'd36;
  localparam logic [OP_W-1:0] OP_ST   = 6'd37;
  localparam logic [OP_W-1:0] OP_BEZ  = 6'd40;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd41;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd42;

  typedef enum logic [MNEM_W-1:0] {
    MN_NOP  = 5'd0,
    MN_ADD  = 5'd1,
    MN_SUB  = 5'd2,
    MN_AND  = 5'd3,
    MN_OR   = 5'd4,
    MN_NOR  = 5'd5,
    MN_XOR  = 5'd6,
    MN_SLA  = 5'd7,
    MN_SLL  = 5'd8,
    MN_SRA  = 5'd9,
    MN_SRL  = 5'd10,
    MN_ADDI = 5'd11,
    MN_SUBI = 5'd12,
    MN_LD   = 5'd13,
    MN_ST   = 5'd14,
    MN_BEZ  = 5'd15,
    MN_BNE  = 5'd16,
    MN_JMP  = 5'd17
  } mnem_e;

  typedef enum logic [2:0] {
    FMT_NOP,  // all-zero word
    FMT_R,    // op, rd, rs1, rs2
    FMT_I,    // op, rd, rs1, imm
    FMT_ST,   // op, rd (value reg), rs1 (base), imm
    FMT_BR,   // op, rs1, imm; rd forced to 0
    FMT_J,    // op, imm; [25:16] forced to 0
    FMT_ILL   // not a defined mnemonic
  } fmt_e;

  typedef struct packed {
    fmt_e            fmt;
    logic [OP_W-1:0] op;
  } mnem_info_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } load_state_e;

  function automatic mnem_info_t mnem_info(input logic [MNEM_W-1:0] mnem);
    mnem_info_t info;
    info = '{fmt: FMT_ILL, op: OP_NOP};
    case (mnem)
      MN_NOP:  info = '{fmt: FMT_NOP, op: OP_NOP};
      MN_ADD:  info = '{fmt: FMT_R,   op: OP_ADD};
      MN_SUB:  info = '{fmt: FMT_R,   op: OP_SUB};
      MN_AND:  info = '{fmt: FMT_R,   op: OP_AND};
      MN_OR:   info = '{fmt: FMT_R,   op: OP_OR};
      MN_NOR:  info = '{fmt: FMT_R,   op: OP_NOR};
      MN_XOR:  info = '{fmt: FMT_R,   op: OP_XOR};
      MN_SLA:  info = '{fmt: FMT_R,   op: OP_SLA};
      MN_SLL:  info = '{fmt: FMT_R,   op: OP_SLL};
      MN_SRA:  info = '{fmt: FMT_R,   op: OP_SRA};
      MN_SRL:  info = '{fmt: FMT_R,   op: OP_SRL};
      MN_ADDI: info = '{fmt: FMT_I,   op: OP_ADDI};
      MN_SUBI: info = '{fmt: FMT_I,   op: OP_SUBI};
      MN_LD:   info = '{fmt: FMT_I,   op: OP_LD};
      MN_ST:   info = '{fmt: FMT_ST,  op: OP_ST};
      MN_BEZ:  info = '{fmt: FMT_BR,  op: OP_BEZ};
      MN_BNE:  info = '{fmt: FMT_BR,  op: OP_BNE};
      MN_JMP:  info = '{fmt: FMT_J,   op: OP_JMP};
      default: info = '{fmt: FMT_ILL, op: OP_NOP};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_if
// Bundles the symbolic command stream (valid/ready) and the instruction-memory
// write port (req/ack) of the loader.
//   slave  : the loader (consumes commands, issues memory writes)
//   master : the environment (produces commands, acknowledges writes)
// -----------------------------------------------------------------------------
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  import calab_isa_pkg::*;

  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic [MNEM_W-1:0] cmd_mnem;
  logic [REG_W-1:0]  cmd_rd;
  logic [REG_W-1:0]  cmd_rs1;
  logic [REG_W-1:0]  cmd_rs2;
  logic [IMM_W-1:0]  cmd_imm;
  logic              cmd_last;

  // Instruction-memory write port
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              imem_ack;

  modport slave (
    input  cmd_valid, cmd_mnem, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready,
    output imem_req, imem_addr, imem_wdata,
    input  imem_ack
  );

  modport master (
    output cmd_valid, cmd_mnem, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready,
    input  imem_req, imem_addr, imem_wdata,
    output imem_ack
  );

endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Pure combinational: symbolic mnemonic + register/immediate fields -> 32-bit
// ISA word, plus a legal flag. Illegal mnemonics yield word=0, legal=0.
// Ports:
//   mnem       in   mnemonic code (mnem_e values; >17 illegal)
//   rd/rs1/rs2 in   register fields
//   imm        in   16-bit immediate / branch offset
//   word       out  encoded instruction
//   legal      out  mnemonic is defined
// -----------------------------------------------------------------------------
module instr_encoder
  import calab_isa_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [IMM_W-1:0]  imm,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  mnem_info_t info;

  assign info = mnem_info(mnem);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    word  = '0;
    legal = 1'b1;
    case (info.fmt)
      FMT_R: begin
        word[OP_LSB  +: OP_W]  = info.op;
        word[RD_LSB  +: REG_W] = rd;
        word[RS1_LSB +: REG_W] = rs1;
        word[RS2_LSB +: REG_W] = rs2;
      end
      FMT_I, FMT_ST: begin
        word[OP_LSB  +: OP_W]  = info.op;
        word[RD_LSB  +: REG_W] = rd;
        word[RS1_LSB +: REG_W] = rs1;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_BR: begin
        // Branches compare rs1 only; the rd field is left zero.
        word[OP_LSB  +: OP_W]  = info.op;
        word[RS1_LSB +: REG_W] = rs1;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_J: begin
        word[OP_LSB  +: OP_W]  = info.op;
        word[IMM_LSB +: IMM_W] = imm;
      end
      FMT_NOP: ;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts symbolic instructions over a valid/ready stream, encodes each into a
// 32-bit ISA word and writes the words to consecutive instruction-memory
// addresses starting at BASE_ADDR over a req/ack port.
// Ports:
//   clk, rst_n  clock / synchronous active-low reset
//   start       begin a load (honoured only in IDLE/DONE)
//   bus         command stream + imem write port (slave side)
//   busy        FSM in LOAD or WRITE
//   done        load finished (level)
//   overflow    DEPTH words written before cmd_last
//   err_count   illegal mnemonics dropped (saturating)
//   word_count  words written this load
// -----------------------------------------------------------------------------
module instr_encoder_loader
  import calab_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_encoder_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W:0]      word_count
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

  load_state_e       state_q, state_nxt;
  logic [WORD_W-1:0] enc_word;
  logic              enc_legal;
  logic [WORD_W-1:0] wdata_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ERR_W-1:0]  err_q;
  logic              ovf_q;

  logic start_ok;
  logic cmd_fire;
  logic ack_fire;
  logic cap_hit;

  instr_encoder u_enc (
    .mnem  (bus.cmd_mnem),
    .rd    (bus.cmd_rd),
    .rs1   (bus.cmd_rs1),
    .rs2   (bus.cmd_rs2),
    .imm   (bus.cmd_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign cmd_fire = (state_q == ST_LOAD) && bus.cmd_valid;
  assign ack_fire = (state_q == ST_WRITE) && bus.imem_ack;
  // The write being acknowledged is the DEPTH-th of this load.
  assign cap_hit  = (wcnt_q + 1'b1) == LIMIT;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (cmd_fire) begin
          if (enc_legal)         state_nxt = ST_WRITE;
          else if (bus.cmd_last) state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (ack_fire) begin
          if (last_q || cap_hit) state_nxt = ST_DONE;
          else                   state_nxt = ST_LOAD;
        end
      end
      ST_DONE:  if (start) state_nxt = ST_LOAD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.cmd_ready = (state_q == ST_LOAD);
    bus.imem_req  = (state_q == ST_WRITE);
    busy          = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    done          = (state_q == ST_DONE);
  end

  // Datapath: latched word, address, counters, flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdata_q <= '0;
      last_q  <= 1'b0;
      addr_q  <= BASE;
      wcnt_q  <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q <= BASE;
        wcnt_q <= '0;
        err_q  <= '0;
        ovf_q  <= 1'b0;
      end
      if (cmd_fire) begin
        if (enc_legal) begin
          wdata_q <= enc_word;
          last_q  <= bus.cmd_last;
        end else if (err_q != '1) begin
          err_q <= err_q + 1'b1;
        end
      end
      if (ack_fire) begin
        wcnt_q <= wcnt_q + 1'b1;
        // Hold the address on the final-capacity write so it never steps
        // past BASE_ADDR+DEPTH-1 (and never wraps for a full-range load).
        if (!cap_hit) addr_q <= addr_q + 1'b1;
        // cmd_last wins over capacity: a full program that ends exactly at
        // DEPTH is not an overflow.
        if (cap_hit && !last_q) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign overflow       = ovf_q;
  assign err_count      = err_q;
  assign word_count     = wcnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench: a table of single-instruction programs with hand-encoded
// words, followed by multi-cycle sequences (two-word load, delayed ack,
// illegal mnemonic, DEPTH overflow, mid-write reset, err_count saturation).
// DUT built with DEPTH=4 so the overflow path is reachable.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int ERR_W  = 8;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (0),
    .DEPTH     (DEPTH),
    .ERR_W     (ERR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .err_count  (err_count),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Count completed memory writes (req and ack high at a rising edge).
  always @(posedge clk) if (bus.imem_req && bus.imem_ack) n_writes++;

  typedef struct {
    logic [4:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
    bit          legal;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_cmd(input logic [4:0] mnem, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [15:0] imm, input bit last,
                          input string tag);
    bus.cmd_mnem  = mnem;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_last  = last;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < TMO && !bus.cmd_ready; i++) tick();
    check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
  endtask

  // Wait for a write request, check address/data, hold ack low for 'delay'
  // cycles (checking the request stays stable and commands are blocked),
  // then acknowledge and check the request drops.
  task automatic serve_write(input int delay, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data, input string tag);
    int   w0;
    bit   stable;
    logic [ADDR_W-1:0] a0;
    logic [31:0] d0;
    w0 = n_writes;
    stable = 1'b1;
    for (int i = 0; i < TMO && !bus.imem_req; i++) tick();
    check({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    check({tag, "_addr"}, 32'(bus.imem_addr), exp_addr);
    check({tag, "_wdata"}, bus.imem_wdata, exp_data);
    a0 = bus.imem_addr;
    d0 = bus.imem_wdata;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (!bus.imem_req || bus.imem_addr !== a0 || bus.imem_wdata !== d0 || bus.cmd_ready)
        stable = 1'b0;
    end
    if (delay > 0) check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check({tag, "_req_drop"}, {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_one_write"}, 32'(n_writes - w0), 32'd1);
  endtask

  initial begin
    int w0;
    bit never_ready;

    vecs[0]  = '{5'd1,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b1, 32'h04221800, "add"};
    vecs[1]  = '{5'd2,  5'd31, 5'd31, 5'd31, 16'h07FF, 1'b1, 32'h0FFFF800, "sub"};
    vecs[2]  = '{5'd5,  5'd0,  5'd1,  5'd1,  16'h0000, 1'b1, 32'h1C010800, "nor"};
    vecs[3]  = '{5'd7,  5'd1,  5'd1,  5'd1,  16'h0000, 1'b1, 32'h24210800, "sla"};
    vecs[4]  = '{5'd10, 5'd2,  5'd4,  5'd6,  16'h0000, 1'b1, 32'h30443000, "srl"};
    vecs[5]  = '{5'd11, 5'd4,  5'd0,  5'd0,  16'hFFFF, 1'b1, 32'h8080FFFF, "addi"};
    vecs[6]  = '{5'd12, 5'd1,  5'd1,  5'd0,  16'h0001, 1'b1, 32'h84210001, "subi"};
    vecs[7]  = '{5'd13, 5'd3,  5'd9,  5'd0,  16'h8000, 1'b1, 32'h90698000, "ld"};
    vecs[8]  = '{5'd14, 5'd5,  5'd6,  5'd0,  16'h1234, 1'b1, 32'h94A61234, "st"};
    vecs[9]  = '{5'd15, 5'd1,  5'd3,  5'd0,  16'h0004, 1'b1, 32'hA0030004, "bez"};
    vecs[10] = '{5'd16, 5'd9,  5'd2,  5'd0,  16'hFFFC, 1'b1, 32'hA402FFFC, "bne"};
    vecs[11] = '{5'd17, 5'd7,  5'd5,  5'd0,  16'h0010, 1'b1, 32'hA8000010, "jmp"};
    vecs[12] = '{5'd0,  5'd3,  5'd4,  5'd0,  16'h0005, 1'b1, 32'h00000000, "nop"};
    vecs[13] = '{5'd18, 5'd1,  5'd1,  5'd1,  16'h0001, 1'b0, 32'h00000000, "ill18"};
    vecs[14] = '{5'd20, 5'd1,  5'd1,  5'd1,  16'h0001, 1'b0, 32'h00000000, "ill20"};
    vecs[15] = '{5'd31, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 32'h00000000, "ill31"};

    rst_n = 1'b0;
    start = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_mnem  = '0;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = '0;
    bus.cmd_last  = 1'b0;
    bus.imem_ack  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_req",   {31'd0, bus.imem_req},  32'd0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},          32'd0);
    check("rst_done",  {31'd0, done},          32'd0);
    check("rst_addr",  32'(bus.imem_addr),     32'd0);
    check("rst_wdata", bus.imem_wdata,         32'd0);
    rst_n = 1'b1;
    tick();

    // Table: one-instruction programs, each ending with cmd_last.
    for (int v = 0; v < 16; v++) begin
      w0 = n_writes;
      pulse_start();
      check({vecs[v].name, "_busy"}, {31'd0, busy}, 32'd1);
      send_cmd(vecs[v].mnem, vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].imm, 1'b1, vecs[v].name);
      if (vecs[v].legal) begin
        serve_write(0, 32'd0, vecs[v].exp, vecs[v].name);
        check({vecs[v].name, "_wcnt"}, 32'(word_count), 32'd1);
        check({vecs[v].name, "_err"},  32'(err_count),  32'd0);
      end else begin
        check({vecs[v].name, "_nowrite"}, 32'(n_writes - w0), 32'd0);
        check({vecs[v].name, "_wcnt"}, 32'(word_count), 32'd0);
        check({vecs[v].name, "_err"},  32'(err_count),  32'd1);
      end
      check({vecs[v].name, "_done"}, {31'd0, done}, 32'd1);
      check({vecs[v].name, "_ovf"},  {31'd0, overflow}, 32'd0);
    end

    // Two-word program; JMP rd/rs1 masked, second word at addr 1.
    pulse_start();
    check("two_wcnt_clr", 32'(word_count), 32'd0);
    send_cmd(5'd11, 5'd4, 5'd0, 5'd0, 16'hFFFF, 1'b0, "two_addi");
    serve_write(0, 32'd0, 32'h8080FFFF, "two_addi");
    check("two_mid_busy", {31'd0, busy}, 32'd1);
    send_cmd(5'd17, 5'd7, 5'd0, 5'd0, 16'h0010, 1'b1, "two_jmp");
    serve_write(0, 32'd1, 32'hA8000010, "two_jmp");
    check("two_done", {31'd0, done}, 32'd1);
    check("two_wcnt", 32'(word_count), 32'd2);

    // Ack delayed 3 cycles.
    pulse_start();
    send_cmd(5'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, "dly_add");
    serve_write(3, 32'd0, 32'h04221800, "dly_add");
    check("dly_wcnt", 32'(word_count), 32'd1);

    // Illegal mnemonic mid-program; start and ack pulses in LOAD ignored.
    pulse_start();
    send_cmd(5'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, "ill_add");
    serve_write(0, 32'd0, 32'h04221800, "ill_add");
    pulse_start();
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("ign_wcnt", 32'(word_count), 32'd1);
    send_cmd(5'd20, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b0, "ill_20");
    check("ill_still_load", {31'd0, bus.cmd_ready}, 32'd1);
    send_cmd(5'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, "ill_sub");
    serve_write(0, 32'd1, 32'h0C221800, "ill_sub");
    check("ill_err",  32'(err_count),  32'd1);
    check("ill_wcnt", 32'(word_count), 32'd2);
    check("ill_done", {31'd0, done},   32'd1);

    // DEPTH overflow: four writes at 0..3, fifth command never accepted.
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send_cmd(5'd1, 5'(i), 5'd2, 5'd3, 16'h0000, 1'b0, "ovf_add");
      serve_write(0, 32'(i), 32'h04021800 | (32'(i) << 21), "ovf_add");
    end
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_done", {31'd0, done},     32'd1);
    check("ovf_wcnt", 32'(word_count),   32'd4);
    w0 = n_writes;
    never_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.cmd_ready || bus.imem_req) never_ready = 1'b0;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("ovf_blocked", {31'd0, never_ready}, 32'd1);
    check("ovf_nowrite", 32'(n_writes - w0), 32'd0);

    // Reset in the middle of a write.
    pulse_start();
    check("rs_ovf_clr", {31'd0, overflow}, 32'd0);
    send_cmd(5'd31, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, "rs_ill");
    send_cmd(5'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, "rs_add0");
    serve_write(0, 32'd0, 32'h04221800, "rs_add0");
    send_cmd(5'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, "rs_add1");
    tick();
    check("rs_pre_req", {31'd0, bus.imem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rs_req",   {31'd0, bus.imem_req},  32'd0);
    check("rs_busy",  {31'd0, busy},          32'd0);
    check("rs_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rs_addr",  32'(bus.imem_addr),     32'd0);
    check("rs_wdata", bus.imem_wdata,         32'd0);
    check("rs_err",   32'(err_count),         32'd0);
    check("rs_wcnt",  32'(word_count),        32'd0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_cmd(5'd17, 5'd0, 5'd0, 5'd0, 16'h0020, 1'b1, "rs_jmp");
    serve_write(0, 32'd0, 32'hA8000020, "rs_jmp");

    // err_count saturation: 260 illegal commands back to back.
    pulse_start();
    bus.cmd_mnem  = 5'd25;
    bus.cmd_last  = 1'b0;
    bus.cmd_valid = 1'b1;
    repeat (260) tick();
    check("sat_err", 32'(err_count), 32'd255);
    check("sat_busy", {31'd0, busy}, 32'd1);
    bus.cmd_last = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_last  = 1'b0;
    check("sat_done", {31'd0, done},   32'd1);
    check("sat_hold", 32'(err_count),  32'd255);
    check("sat_wcnt", 32'(word_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
